control_sync_hora: RTL and testbench

Controller that owns time-of-day acquisition over the serial byte link and keeps the time afterwards. It requests the time from the host, collects and checks the six-digit ASCII frame, and loads it into a local HHMMSS clock. That clock then free-runs and is resynchronised periodically or on demand. It sits between the UART receive/transmit byte interfaces and the display/alarm logic that consumes `hora`.

---
 rtl/control_sync_hora_pkg.sv | 29 ++
 rtl/control_sync_hora_reloj_ascii.sv | 63 ++++++
 rtl/control_sync_hora.sv | 246 ++++++++++++++++++++++++
 tb/tb_control_sync_hora.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/control_sync_hora_pkg.sv
// Shared constants, FSM state encoding and helpers for the time-sync controller.
package control_sync_hora_pkg;

    localparam logic [7:0] ASCII_Z   = 8'd122;
    localparam logic [7:0] ASCII_REQ = 8'd63;
    localparam logic [7:0] ASCII_0   = 8'h30;
    localparam logic [7:0] ASCII_2   = 8'h32;
    localparam logic [7:0] ASCII_3   = 8'h33;
    localparam logic [7:0] ASCII_5   = 8'h35;
    localparam logic [7:0] ASCII_9   = 8'h39;

    // "000000" in byte-per-digit ASCII form
    localparam logic [47:0] HORA_RST = 48'h303030303030;

    typedef enum logic [2:0] {
        ST_IDLE           = 3'd0,
        ST_SOLICITAR      = 3'd1,
        ST_ESPERAR_INICIO = 3'd2,
        ST_RECIBIR        = 3'd3,
        ST_ESPERAR_FIN    = 3'd4,
        ST_CARGAR         = 3'd5,
        ST_CORRIENDO      = 3'd6
    } state_t;

    function automatic logic es_digito(input logic [7:0] b);
        return (b >= ASCII_0) && (b <= ASCII_9);
    endfunction

endpackage

// File: rtl/control_sync_hora_reloj_ascii.sv
// ASCII HHMMSS counter: byte 0 = H tens ... byte 5 = S units. Load beats tick.
module reloj_ascii
    import control_sync_hora_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [47:0] load_val,
    input  logic        tick,
    output logic [47:0] hora
);

    logic [47:0] r_hora;
    logic [47:0] w_hora_inc;

    // Next value after one second, rippling carries S units -> H tens
    always_comb begin
        w_hora_inc = r_hora;
        if (r_hora[47:40] != ASCII_9) begin
            w_hora_inc[47:40] = r_hora[47:40] + 8'd1;
        end else begin
            w_hora_inc[47:40] = ASCII_0;
            if (r_hora[39:32] != ASCII_5) begin
                w_hora_inc[39:32] = r_hora[39:32] + 8'd1;
            end else begin
                w_hora_inc[39:32] = ASCII_0;
                if (r_hora[31:24] != ASCII_9) begin
                    w_hora_inc[31:24] = r_hora[31:24] + 8'd1;
                end else begin
                    w_hora_inc[31:24] = ASCII_0;
                    if (r_hora[23:16] != ASCII_5) begin
                        w_hora_inc[23:16] = r_hora[23:16] + 8'd1;
                    end else begin
                        w_hora_inc[23:16] = ASCII_0;
                        if ((r_hora[7:0] == ASCII_2) && (r_hora[15:8] == ASCII_3)) begin
                            w_hora_inc[7:0]  = ASCII_0;
                            w_hora_inc[15:8] = ASCII_0;
                        end else if (r_hora[15:8] == ASCII_9) begin
                            w_hora_inc[15:8] = ASCII_0;
                            w_hora_inc[7:0]  = r_hora[7:0] + 8'd1;
                        end else begin
                            w_hora_inc[15:8] = r_hora[15:8] + 8'd1;
                        end
                    end
                end
            end
        end
    end

    // Time register: load has priority over the seconds tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hora <= HORA_RST;
        end else if (load) begin
            r_hora <= load_val;
        end else if (tick) begin
            r_hora <= w_hora_inc;
        end
    end

    assign hora = r_hora;

endmodule

// File: rtl/control_sync_hora.sv
// Time-of-day acquisition over the byte link, frame validation and local clock.
module control_sync_hora
    import control_sync_hora_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int TIMEOUT_MS  = 500,
    parameter int MAX_RETRIES = 3,
    parameter int RESYNC_S    = 3600
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_dato,
    input  logic        rx_valid,
    input  logic        tx_ready,
    input  logic        sync_req,
    output logic [7:0]  tx_dato,
    output logic        tx_valid,
    output logic [47:0] hora,
    output logic        hora_valida,
    output logic        sync_done,
    output logic        sync_error
);

    localparam int MS_DIV = (CLK_HZ >= 1000) ? (CLK_HZ / 1000) : 1;
    localparam int MS_W   = $clog2(MS_DIV + 1);
    localparam int S_W    = $clog2(CLK_HZ + 1);
    localparam int TO_W   = $clog2(TIMEOUT_MS + 1);
    localparam int RT_W   = $clog2(MAX_RETRIES + 1);
    localparam int RS_W   = $clog2(RESYNC_S + 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [MS_W-1:0]   r_ms_div;
    logic [S_W-1:0]    r_s_div;
    logic [TO_W-1:0]   r_to_cnt;
    logic [RT_W-1:0]   r_retry;
    logic [RT_W-1:0]   w_retry_inc;
    logic [RS_W-1:0]   r_resync;
    logic [2:0]        r_idx;
    logic [47:0]       r_shadow;
    logic              r_hora_valida;
    logic              r_sync_done;
    logic              r_sync_error;

    logic w_ms_tick;
    logic w_s_tick_raw;
    logic w_s_tick;
    logic w_espera;
    logic w_timeout;
    logic w_digit_ok;
    logic w_tx_valid;
    logic w_load;
    logic w_digit_we;
    logic w_idx_clr;
    logic w_to_clr;
    logic w_fail;
    logic w_run_entry;

    assign w_ms_tick    = (r_ms_div == MS_W'(MS_DIV - 1));
    assign w_s_tick_raw = (r_s_div == S_W'(CLK_HZ - 1));
    // A second boundary coinciding with a load is dropped; the loaded time wins
    assign w_s_tick     = w_s_tick_raw && !w_load;
    assign w_espera     = (r_state == ST_ESPERAR_INICIO) || (r_state == ST_RECIBIR) ||
                          (r_state == ST_ESPERAR_FIN);
    assign w_timeout    = w_espera && (r_to_cnt == TO_W'(TIMEOUT_MS));
    assign w_retry_inc  = r_retry + RT_W'(1);

    // Per-position digit range check; H units depends on the stored H tens
    always_comb begin
        w_digit_ok = es_digito(rx_dato);
        case (r_idx)
            3'd0:    if (rx_dato > ASCII_2) w_digit_ok = 1'b0;
            3'd1:    if ((r_shadow[7:0] == ASCII_2) && (rx_dato > ASCII_3)) w_digit_ok = 1'b0;
            3'd2:    if (rx_dato > ASCII_5) w_digit_ok = 1'b0;
            3'd4:    if (rx_dato > ASCII_5) w_digit_ok = 1'b0;
            default: ;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and control strobes; a received byte always beats a timeout
    always_comb begin
        w_state_next = r_state;
        w_tx_valid   = 1'b0;
        w_load       = 1'b0;
        w_digit_we   = 1'b0;
        w_idx_clr    = 1'b0;
        w_to_clr     = 1'b0;
        w_fail       = 1'b0;
        w_run_entry  = 1'b0;
        case (r_state)
            ST_IDLE: w_state_next = ST_SOLICITAR;
            ST_SOLICITAR: begin
                w_tx_valid = 1'b1;
                if (tx_ready) begin
                    w_to_clr     = 1'b1;
                    w_state_next = ST_ESPERAR_INICIO;
                end
            end
            ST_ESPERAR_INICIO: begin
                if (rx_valid) begin
                    if (rx_dato == ASCII_Z) begin
                        w_idx_clr    = 1'b1;
                        w_state_next = ST_RECIBIR;
                    end
                end else if (w_timeout) begin
                    w_fail = 1'b1;
                end
            end
            ST_RECIBIR: begin
                if (rx_valid) begin
                    if (rx_dato == ASCII_Z) begin
                        w_idx_clr = 1'b1;
                    end else if (w_digit_ok) begin
                        w_digit_we = 1'b1;
                        if (r_idx == 3'd5) w_state_next = ST_ESPERAR_FIN;
                    end else begin
                        w_fail = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_fail = 1'b1;
                end
            end
            ST_ESPERAR_FIN: begin
                if (rx_valid) begin
                    if (rx_dato == ASCII_Z) w_state_next = ST_CARGAR;
                    else                    w_fail       = 1'b1;
                end else if (w_timeout) begin
                    w_fail = 1'b1;
                end
            end
            ST_CARGAR: begin
                w_load       = 1'b1;
                w_run_entry  = 1'b1;
                w_state_next = ST_CORRIENDO;
            end
            ST_CORRIENDO: begin
                if (sync_req || (r_resync == RS_W'(RESYNC_S))) w_state_next = ST_SOLICITAR;
            end
            default: w_state_next = ST_IDLE;
        endcase
        if (w_fail) begin
            if (w_retry_inc < RT_W'(MAX_RETRIES)) begin
                w_state_next = ST_SOLICITAR;
            end else begin
                w_state_next = ST_CORRIENDO;
                w_run_entry  = 1'b1;
            end
        end
    end

    // Millisecond and second dividers; the second divider realigns on each load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ms_div <= '0;
            r_s_div  <= '0;
        end else begin
            r_ms_div <= w_ms_tick ? '0 : r_ms_div + MS_W'(1);
            if (w_load || w_s_tick_raw) r_s_div <= '0;
            else                        r_s_div <= r_s_div + S_W'(1);
        end
    end

    // Reply timeout in ms since the request handshake, saturating at the limit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (w_to_clr) begin
            r_to_cnt <= '0;
        end else if (w_espera && w_ms_tick && (r_to_cnt != TO_W'(TIMEOUT_MS))) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    // Frame digit collection into the shadow register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx    <= '0;
            r_shadow <= HORA_RST;
        end else if (w_idx_clr) begin
            r_idx <= '0;
        end else if (w_digit_we) begin
            r_shadow[{r_idx, 3'b000} +: 8] <= rx_dato;
            r_idx                          <= r_idx + 3'd1;
        end
    end

    // Retry accounting and sync status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retry       <= '0;
            r_sync_error  <= 1'b0;
            r_hora_valida <= 1'b0;
            r_sync_done   <= 1'b0;
        end else begin
            r_sync_done <= w_load;
            if (w_load) begin
                r_retry       <= '0;
                r_sync_error  <= 1'b0;
                r_hora_valida <= 1'b1;
            end else if (w_fail) begin
                if (w_retry_inc < RT_W'(MAX_RETRIES)) begin
                    r_retry <= w_retry_inc;
                end else begin
                    r_retry      <= '0;
                    r_sync_error <= 1'b1;
                end
            end
        end
    end

    // Seconds spent in CORRIENDO since entry, for the periodic resync
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resync <= '0;
        end else if (w_run_entry) begin
            r_resync <= '0;
        end else if ((r_state == ST_CORRIENDO) && w_s_tick && (r_resync != RS_W'(RESYNC_S))) begin
            r_resync <= r_resync + RS_W'(1);
        end
    end

    reloj_ascii u_reloj (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (r_shadow),
        .tick     (w_s_tick),
        .hora     (hora)
    );

    assign tx_dato     = ASCII_REQ;
    assign tx_valid    = w_tx_valid;
    assign hora_valida = r_hora_valida;
    assign sync_done   = r_sync_done;
    assign sync_error  = r_sync_error;

endmodule

// File: tb/tb_control_sync_hora.sv
// Directed bench: small dividers (1 ms = 1 cycle, 1 s = 1000 cycles), RESYNC_S=2.
module tb_control_sync_hora;
    import control_sync_hora_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_dato;
    logic        rx_valid;
    logic        tx_ready;
    logic        sync_req;
    logic [7:0]  tx_dato;
    logic        tx_valid;
    logic [47:0] hora;
    logic        hora_valida;
    logic        sync_done;
    logic        sync_error;

    int n_checks = 0;
    int n_fail   = 0;
    int req_cnt  = 0;
    int done_cnt = 0;
    int base;
    int cnt;

    control_sync_hora #(
        .CLK_HZ      (1000),
        .TIMEOUT_MS  (20),
        .MAX_RETRIES (3),
        .RESYNC_S    (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_dato     (rx_dato),
        .rx_valid    (rx_valid),
        .tx_ready    (tx_ready),
        .sync_req    (sync_req),
        .tx_dato     (tx_dato),
        .tx_valid    (tx_valid),
        .hora        (hora),
        .hora_valida (hora_valida),
        .sync_done   (sync_done),
        .sync_error  (sync_error)
    );

    always #5 clk = ~clk;

    // Count accepted requests and load pulses
    always @(posedge clk) begin
        if (tx_valid && tx_ready) req_cnt++;
        if (sync_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    // byte k of hora holds the k-th character of the string
    function automatic logic [47:0] to_hora(input string s);
        logic [47:0] h;
        for (int k = 0; k < 6; k++) h[8*k +: 8] = s[k];
        return h;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_dato  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic send_frame(input string digits);
        send_byte(ASCII_Z);
        send_str(digits);
        send_byte(ASCII_Z);
    endtask

    task automatic wait_req(input int target, input string tag);
        for (int i = 0; i < 100 && req_cnt < target; i++) @(negedge clk);
        check(tag, req_cnt, target);
    endtask

    task automatic pulse_sync_req();
        @(negedge clk);
        sync_req = 1'b1;
        @(negedge clk);
        sync_req = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        rx_dato  = 8'd0;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        sync_req = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hora", hora, to_hora("000000"));
        check("rst_valida", hora_valida, 0);
        check("rst_done", sync_done, 0);
        check("rst_error", sync_error, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_dato", tx_dato, 63);
        check("rst_state", 64'(dut.r_state), 64'(ST_IDLE));

        // First acquisition
        rst      = 1'b0;
        tx_ready = 1'b1;
        wait_req(1, "req_first");
        send_frame("123456");
        check("done_before", sync_done, 0);
        @(negedge clk);
        check("done_pulse", sync_done, 1);
        check("hora_123456", hora, to_hora("123456"));
        @(negedge clk);
        check("done_low", sync_done, 0);
        check("valida_set", hora_valida, 1);
        check("one_request", req_cnt, 1);
        check("done_count", done_cnt, 1);

        // Midnight wrap
        pulse_sync_req();
        wait_req(2, "req_235959");
        send_frame("235959");
        @(negedge clk);
        check("hora_235959", hora, to_hora("235959"));
        repeat (990) @(negedge clk);
        check("before_tick", hora, to_hora("235959"));
        repeat (13) @(negedge clk);
        check("wrap_000000", hora, to_hora("000000"));

        // Bad H units digit
        base = req_cnt;
        pulse_sync_req();
        wait_req(base + 1, "req_bad");
        send_str("z24");
        wait_req(base + 2, "resend_bad");
        check("hora_kept", hora, to_hora("000000"));
        check("no_error_yet", sync_error, 0);
        send_frame("120000");
        @(negedge clk);
        check("hora_120000", hora, to_hora("120000"));
        @(negedge clk);

        // No reply: retries exhausted
        base = req_cnt;
        pulse_sync_req();
        for (int i = 0; i < 400 && !sync_error; i++) @(negedge clk);
        check("error_set", sync_error, 1);
        check("three_requests", req_cnt, base + 3);
        check("state_run", 64'(dut.r_state), 64'(ST_CORRIENDO));
        check("tx_idle", tx_valid, 0);
        repeat (1000) @(negedge clk);
        check("ticking", hora, to_hora("120001"));
        check("valida_kept", hora_valida, 1);

        // On-demand resync then reset mid-frame
        base = req_cnt;
        pulse_sync_req();
        wait_req(base + 1, "req_081500");
        send_frame("081500");
        @(negedge clk);
        check("hora_081500", hora, to_hora("081500"));
        check("error_clr", sync_error, 0);
        @(negedge clk);
        base = req_cnt;
        pulse_sync_req();
        wait_req(base + 1, "req_second");
        send_str("z08");
        rst = 1'b1;
        #1;
        check("mid_rst_hora", hora, to_hora("000000"));
        check("mid_rst_valida", hora_valida, 0);
        check("mid_rst_tx", tx_valid, 0);
        check("mid_rst_state", 64'(dut.r_state), 64'(ST_IDLE));
        @(negedge clk);
        rst  = 1'b0;
        base = req_cnt;
        wait_req(base + 1, "req_after_rst");

        // Automatic resync after RESYNC_S seconds
        send_frame("101010");
        @(negedge clk);
        check("hora_101010", hora, to_hora("101010"));
        cnt = 0;
        while (!tx_valid && cnt < 3000) begin
            @(negedge clk);
            cnt++;
        end
        check("resync_cycles", cnt, 2001);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
